// File: rtl/chroma_upsampler.sv
// Horizontal 2:1 chroma upsampler. Reads one downsampled U or V plane
// (two samples per word), rebuilds the odd samples with a 6-tap FIR and
// writes one word per output pair: even sample in [7:0], odd in [15:8].
module chroma_upsampler #(
    parameter int          IN_WIDTH = 160,
    parameter int          ROWS     = 240,
    parameter int          ADDR_W   = 18,
    parameter int unsigned SRC_BASE = 0,
    parameter int unsigned DST_BASE = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W-1:0] R_addr,
    input  logic [15:0]       R_data,
    output logic [ADDR_W-1:0] W_addr,
    output logic [15:0]       W_data,
    output logic              W_en
);
    localparam int HALF_W = IN_WIDTH / 2;
    localparam int CW     = $clog2(IN_WIDTH);
    localparam int WW     = $clog2(HALF_W + 1);
    localparam int RW     = $clog2(ROWS + 1);
    localparam logic [CW-1:0]     COL_LAST = CW'(IN_WIDTH - 1);
    localparam logic [RW-1:0]     ROW_LAST = RW'(ROWS - 1);
    localparam logic [ADDR_W-1:0] SRC_A    = ADDR_W'(SRC_BASE);
    localparam logic [ADDR_W-1:0] DST_A    = ADDR_W'(DST_BASE);
    localparam logic [ADDR_W-1:0] HALF_A   = ADDR_W'(HALF_W);
    localparam logic [WW-1:0]     HALF_WW  = WW'(HALF_W);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_PRIME    = 3'd1,
        S_RUN      = 3'd2,
        S_NEXT_ROW = 3'd3,
        S_DONE     = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [1:0]          phase_q, phase_d;
    logic [CW-1:0]       col_q, col_d;
    logic [RW-1:0]       row_q, row_d;
    logic [WW-1:0]       rd_word_q, rd_word_d;
    logic [ADDR_W-1:0]   src_row_q, src_row_d;
    logic [ADDR_W-1:0]   raddr_q, raddr_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [5:0][7:0]     win_q, win_d;
    logic [7:0]          buf_q, buf_d;
    logic [7:0]          new_s;
    logic                repl_s;

    // 6-tap half-band interpolator with rounding, clamped to 0..255.
    // Positive and negative taps are summed separately; the difference
    // is an 18-bit two's-complement value that never overflows.
    function automatic logic [7:0] fir6(input logic [5:0][7:0] w);
        logic [17:0] pos;
        logic [17:0] neg;
        logic [17:0] s;
        pos = 18'd21  * (18'(w[0]) + 18'(w[5]))
            + 18'd159 * (18'(w[2]) + 18'(w[3])) + 18'd128;
        neg = 18'd52  * (18'(w[1]) + 18'(w[4]));
        s   = pos - neg;
        if (s[17]) begin
            fir6 = 8'd0;
        end else if (s[16]) begin
            fir6 = 8'd255;
        end else begin
            fir6 = s[15:8];
        end
    endfunction

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:     if (start) state_d = S_PRIME;    else state_d = S_IDLE;
            S_PRIME:    if (phase_q == 2'd2) state_d = S_RUN; else state_d = S_PRIME;
            S_RUN:      if (col_q == COL_LAST) state_d = S_NEXT_ROW; else state_d = S_RUN;
            S_NEXT_ROW: if (row_q == ROW_LAST) state_d = S_DONE; else state_d = S_PRIME;
            S_DONE:     state_d = S_IDLE;
            default:    state_d = S_IDLE;
        endcase
    end

    // FSM outputs; W_data is driven straight from the window during RUN
    always_comb begin
        busy   = 1'b0;
        done   = 1'b0;
        W_en   = 1'b0;
        W_data = 16'h0000;
        case (state_q)
            S_PRIME, S_NEXT_ROW: busy = 1'b1;
            S_RUN: begin
                busy   = 1'b1;
                W_en   = 1'b1;
                W_data = {fir6(win_q), win_q[2]};
            end
            S_DONE:  done = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    assign R_addr = raddr_q;
    assign W_addr = waddr_q;

    // Datapath next state: read scheduling, window shifting, counters
    always_comb begin
        phase_d   = phase_q;
        col_d     = col_q;
        row_d     = row_q;
        rd_word_d = rd_word_q;
        src_row_d = src_row_q;
        raddr_d   = raddr_q;
        waddr_d   = waddr_q;
        win_d     = win_q;
        buf_d     = buf_q;
        // Once U[j+4] lies past the row end, w5 already holds U[W-1].
        repl_s    = ({1'b0, col_q} + (CW+1)'(4)) >= (CW+1)'(IN_WIDTH);
        new_s     = win_q[5];
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    phase_d   = 2'd0;
                    col_d     = '0;
                    row_d     = '0;
                    rd_word_d = WW'(1);
                    src_row_d = SRC_A;
                    raddr_d   = SRC_A;
                    waddr_d   = DST_A;
                end else begin
                    phase_d = phase_q;
                end
            end
            S_PRIME: begin
                phase_d = phase_q + 2'd1;
                if (phase_q == 2'd0) begin
                    raddr_d   = src_row_q + ADDR_W'(1);
                    rd_word_d = WW'(2);
                end else if (phase_q == 2'd1) begin
                    // Word 0 arrives: U[-2] = U[-1] = U[0].
                    win_d[0] = R_data[7:0];
                    win_d[1] = R_data[7:0];
                    win_d[2] = R_data[7:0];
                    win_d[3] = R_data[15:8];
                    if (rd_word_q < HALF_WW) begin
                        raddr_d   = src_row_q + ADDR_W'(rd_word_q);
                        rd_word_d = rd_word_q + WW'(1);
                    end else begin
                        raddr_d = raddr_q;
                    end
                end else begin
                    win_d[4] = R_data[7:0];
                    win_d[5] = R_data[15:8];
                    phase_d  = 2'd0;
                    col_d    = '0;
                end
            end
            S_RUN: begin
                // Even columns take the low byte of the word arriving now
                // and park the high byte for the following odd column.
                if (repl_s) begin
                    new_s = win_q[5];
                end else if (!col_q[0]) begin
                    new_s = R_data[7:0];
                end else begin
                    new_s = buf_q;
                end
                if (!col_q[0]) buf_d = R_data[15:8]; else buf_d = buf_q;
                win_d   = {new_s, win_q[5:1]};
                col_d   = col_q + CW'(1);
                waddr_d = waddr_q + ADDR_W'(1);
                if (!col_q[0] && (rd_word_q < HALF_WW)) begin
                    raddr_d   = src_row_q + ADDR_W'(rd_word_q);
                    rd_word_d = rd_word_q + WW'(1);
                end else begin
                    raddr_d = raddr_q;
                end
            end
            S_NEXT_ROW: begin
                row_d     = row_q + RW'(1);
                src_row_d = src_row_q + HALF_A;
                rd_word_d = WW'(1);
                phase_d   = 2'd0;
                if (row_q != ROW_LAST) raddr_d = src_row_q + HALF_A; else raddr_d = raddr_q;
            end
            default: phase_d = phase_q;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            phase_q   <= 2'd0;
            col_q     <= '0;
            row_q     <= '0;
            rd_word_q <= '0;
            src_row_q <= '0;
            raddr_q   <= '0;
            waddr_q   <= '0;
            win_q     <= '0;
            buf_q     <= 8'd0;
        end else begin
            phase_q   <= phase_d;
            col_q     <= col_d;
            row_q     <= row_d;
            rd_word_q <= rd_word_d;
            src_row_q <= src_row_d;
            raddr_q   <= raddr_d;
            waddr_q   <= waddr_d;
            win_q     <= win_d;
            buf_q     <= buf_d;
        end
    end
endmodule

// File: tb/tb_chroma_upsampler.sv
// Scoreboard bench for chroma_upsampler: a full-size instance with
// patterned rows and a 4x2 instance for timing and control corner cases.
`timescale 1ns/1ps
module tb_chroma_upsampler;
    localparam int AW = 160, AR = 240, BW = 4, BR = 2;
    localparam int AWORDS = AW / 2 * AR, BWORDS = BW / 2 * BR;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic        a_start, a_busy, a_done, a_wen;
    logic [17:0] a_raddr, a_waddr;
    logic [15:0] a_rdata, a_wdata;
    logic        b_start, b_busy, b_done, b_wen;
    logic [17:0] b_raddr, b_waddr;
    logic [15:0] b_rdata, b_wdata;

    chroma_upsampler u_a (
        .clk(clk), .rst(rst), .start(a_start), .busy(a_busy), .done(a_done),
        .R_addr(a_raddr), .R_data(a_rdata), .W_addr(a_waddr), .W_data(a_wdata), .W_en(a_wen));

    chroma_upsampler #(.IN_WIDTH(BW), .ROWS(BR)) u_b (
        .clk(clk), .rst(rst), .start(b_start), .busy(b_busy), .done(b_done),
        .R_addr(b_raddr), .R_data(b_rdata), .W_addr(b_waddr), .W_data(b_wdata), .W_en(b_wen));

    logic [15:0] mem_a [AWORDS];
    logic [15:0] mem_b [BWORDS];

    // memories: data valid the cycle after the address
    always @(posedge clk) begin
        a_rdata <= (int'(a_raddr) < AWORDS) ? mem_a[int'(a_raddr)] : 16'hDEAD;
        b_rdata <= (int'(b_raddr) < BWORDS) ? mem_b[int'(b_raddr)] : 16'hDEAD;
    end

    int total = 0;
    int bad   = 0;

    int          qa_addr[$];
    logic [15:0] qa_data[$];
    int          qb_addr[$];
    logic [15:0] qb_data[$];

    // hand-computed spot values in the full-size plane
    int          spot_addr [9] = '{0, 1, 10, 159, 162, 164, 325, 487, 38399};
    logic [15:0] spot_data [9] = '{16'h0000, 16'h0201, 16'h0B0A, 16'h9F9F, 16'hFFFF,
                                   16'h0000, 16'h0000, 16'hC8C8, 16'h6464};

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // row patterns of the full-size plane
    function automatic int val_a(input int row, input int j);
        if (row == 0) return j;
        if (row == 1) return ((j % 4) < 2) ? 0 : 255;
        if (row == 2) return 0;
        if (row == 3) return 200;
        return 100;
    endfunction

    function automatic int samp(input bit sel, input int row, input int j, input int wid);
        int jj;
        int wd;
        logic [15:0] word;
        jj = (j < 0) ? 0 : ((j > wid - 1) ? wid - 1 : j);
        wd = row * (wid / 2) + jj / 2;
        word = sel ? mem_b[wd] : mem_a[wd];
        return (jj % 2 == 1) ? int'(word[15:8]) : int'(word[7:0]);
    endfunction

    // reference: {clamp((taps + 128) >> 8), U[j]} with per-row edge replication
    function automatic logic [15:0] model(input bit sel, input int row, input int j);
        int wid;
        int a [6];
        int s;
        int f;
        wid = sel ? BW : AW;
        for (int t = 0; t < 6; t++) a[t] = samp(sel, row, j - 2 + t, wid);
        s = 21*a[0] - 52*a[1] + 159*a[2] + 159*a[3] - 52*a[4] + 21*a[5] + 128;
        if (s < 0) f = 0;
        else begin
            f = s / 256;
            if (f > 255) f = 255;
        end
        return {8'(f), 8'(a[2])};
    endfunction

    task automatic push_a();
        for (int r = 0; r < AR; r++)
            for (int j = 0; j < AW; j++) begin
                qa_addr.push_back(r * AW + j);
                if (r < 2)       qa_data.push_back(model(1'b0, r, j));
                else if (r == 2) qa_data.push_back(16'h0000);
                else if (r == 3) qa_data.push_back(16'hC8C8);
                else             qa_data.push_back(16'h6464);
            end
    endtask

    task automatic push_b();
        for (int r = 0; r < BR; r++)
            for (int j = 0; j < BW; j++) begin
                qb_addr.push_back(r * BW + j);
                qb_data.push_back(model(1'b1, r, j));
            end
    endtask

    // monitor for the full-size instance
    always @(negedge clk) begin
        int ea;
        logic [15:0] ed;
        if (a_wen) begin
            if (qa_addr.size() == 0) begin
                total++; bad++;
                $display("FAIL wrA_unexpected: write to %0h, none expected", a_waddr);
            end else begin
                ea = qa_addr.pop_front();
                ed = qa_data.pop_front();
                check("wrA", {a_waddr, a_wdata}, {18'(ea), ed});
                for (int s = 0; s < 9; s++)
                    if (int'(a_waddr) == spot_addr[s]) check("spotA", a_wdata, spot_data[s]);
            end
        end
    end

    // monitor for the small instance
    always @(negedge clk) begin
        int ea;
        logic [15:0] ed;
        if (b_wen) begin
            if (qb_addr.size() == 0) begin
                total++; bad++;
                $display("FAIL wrB_unexpected: write to %0h, none expected", b_waddr);
            end else begin
                ea = qb_addr.pop_front();
                ed = qb_data.pop_front();
                check("wrB", {b_waddr, b_wdata}, {18'(ea), ed});
            end
        end
    end

    // Pulse start (cycle 0) and observe cycles 1..limit; optional extra start pulse
    task automatic run_plane(input bit sel, input int limit, input int pulse_at, input bit chk_wen,
                             output int busy_n, output int done_at, output int wr_n, output int rd_n);
        logic [17:0] prev;
        logic cb, cw, cd;
        logic [17:0] ra;
        int c;
        busy_n = 0; done_at = -1; wr_n = 0; rd_n = 0; prev = '0;
        @(negedge clk);
        if (sel) b_start = 1'b1; else a_start = 1'b1;
        @(negedge clk);
        a_start = 1'b0; b_start = 1'b0;
        c = 1;
        while (c <= limit && done_at < 0) begin
            cb = sel ? b_busy : a_busy;
            cw = sel ? b_wen : a_wen;
            cd = sel ? b_done : a_done;
            ra = sel ? b_raddr : a_raddr;
            if (cb) begin
                busy_n++;
                if (busy_n == 1 || ra != prev) rd_n++;
            end
            prev = ra;
            if (cw) wr_n++;
            if (chk_wen) check("wen_cycle", {32'(c), 31'd0, cw},
                               {32'(c), 31'd0, ((c >= 4 && c <= 7) || (c >= 12 && c <= 15))});
            if (cd) done_at = c;
            if (c == pulse_at) begin
                if (sel) b_start = 1'b1; else a_start = 1'b1;
            end else begin
                a_start = 1'b0; b_start = 1'b0;
            end
            @(negedge clk);
            c++;
        end
        a_start = 1'b0; b_start = 1'b0;
    endtask

    int bn, da, wn, rn, n;

    initial begin
        rst = 1'b1; a_start = 1'b0; b_start = 1'b0;
        for (int r = 0; r < AR; r++)
            for (int k = 0; k < AW / 2; k++)
                mem_a[r * (AW / 2) + k] = {8'(val_a(r, 2*k + 1)), 8'(val_a(r, 2*k))};
        mem_b[0] = 16'h140A; mem_b[1] = 16'h281E;
        mem_b[2] = 16'hFF00; mem_b[3] = 16'h00FF;
        repeat (3) @(negedge clk);
        check("reset_A", {a_busy, a_done, a_wen, a_raddr, a_waddr, a_wdata}, 64'd0);
        check("reset_B", {b_busy, b_done, b_wen, b_raddr, b_waddr, b_wdata}, 64'd0);
        rst = 1'b0;
        @(negedge clk);

        // full-size plane: ramp, clamp, zero, 200 rows, then constant 100
        push_a();
        run_plane(1'b0, 40000, -1, 1'b0, bn, da, wn, rn);
        check("A_busy_cycles", bn, 39360);
        check("A_done_cycle", da, 39361);
        check("A_writes", wn, 38400);
        check("A_reads", rn, 19200);
        check("A_left", qa_addr.size(), 0);

        // small plane timing
        push_b();
        run_plane(1'b1, 40, -1, 1'b1, bn, da, wn, rn);
        check("B_busy_cycles", bn, 16);
        check("B_done_cycle", da, 17);
        check("B_writes", wn, 8);
        check("B_reads", rn, 4);
        check("B_left", qb_addr.size(), 0);

        // start pulsed in the middle of RUN is ignored
        push_b();
        run_plane(1'b1, 40, 6, 1'b0, bn, da, wn, rn);
        check("Bmid_busy_cycles", bn, 16);
        check("Bmid_done_cycle", da, 17);
        check("Bmid_writes", wn, 8);
        check("Bmid_reads", rn, 4);
        check("Bmid_left", qb_addr.size(), 0);

        // reset during RUN aborts the plane
        push_b();
        @(negedge clk); b_start = 1'b1;
        @(negedge clk); b_start = 1'b0;
        repeat (4) @(negedge clk);
        check("Brst_in_run", b_wen, 1'b1);
        rst = 1'b1;
        #1;
        check("Brst_outputs", {b_busy, b_done, b_wen, b_raddr, b_waddr, b_wdata}, 64'd0);
        qb_addr.delete(); qb_data.delete();
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        n = 0;
        for (int c = 0; c < 30; c++) begin
            @(negedge clk);
            if (b_wen || b_done || b_busy) n++;
        end
        check("Brst_activity_after", n, 0);

        // a fresh start afterwards completes normally
        push_b();
        run_plane(1'b1, 40, -1, 1'b0, bn, da, wn, rn);
        check("Bre_busy_cycles", bn, 16);
        check("Bre_done_cycle", da, 17);
        check("Bre_writes", wn, 8);
        check("Bre_reads", rn, 4);
        check("Bre_left", qb_addr.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
